// File: rtl/msg_out_buffer_if.sv
// msg_out_buffer port bundle: decoder-side write channel
// plus the downstream valid/ready replay channel.
interface msg_out_buffer_if #(
  parameter int DATA_WIDTH      = 256,
  parameter int BYTE_MASK_WIDTH = 32
);
  logic                       inValid;
  logic [DATA_WIDTH-1:0]      inData;
  logic [BYTE_MASK_WIDTH-1:0] inByteMask;
  logic                       outValid;
  logic                       outReady;
  logic [DATA_WIDTH-1:0]      outData;
  logic [BYTE_MASK_WIDTH-1:0] outByteMask;
  logic [5:0]                 outLength;
  logic                       almostFull;
  logic                       overflow;

  modport master (
    output inValid, inData, inByteMask, outReady,
    input  outValid, outData, outByteMask,
    input  outLength, almostFull, overflow
  );

  modport slave (
    input  inValid, inData, inByteMask, outReady,
    output outValid, outData, outByteMask,
    output outLength, almostFull, overflow
  );
endinterface

// File: rtl/msg_out_buffer.sv
// Elastic output buffer behind the message decoder.
// Optional counters: define MSG_OUT_BUF_STATS_EN.
module msg_out_buffer #(
  parameter int DATA_WIDTH      = 256,
  parameter int BYTE_MASK_WIDTH = 32,
  parameter int DEPTH           = 8,
  parameter int AFULL_THRESH    = 6
) (
  input  logic        clk,
  input  logic        reset,
`ifdef MSG_OUT_BUF_STATS_EN
  output logic [31:0] msgCount,
  output logic [15:0] dropCount,
`endif
  msg_out_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]      data;
    logic [BYTE_MASK_WIDTH-1:0] mask;
    logic [5:0]                 len;
  } entry_t;

  function automatic logic [5:0] popcnt(
    input logic [BYTE_MASK_WIDTH-1:0] m
  );
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < BYTE_MASK_WIDTH; i++)
      n = n + {5'd0, m[i]};
    return n;
  endfunction

  entry_t          mem_q [DEPTH];
  entry_t          head;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            valid, pop, vin, push, drop;

  // Handshake decode and next-state for pointers, count, overflow
  always_comb begin
    valid      = (count_q != '0);
    pop        = valid & bus.outReady;
    vin        = bus.inValid & (|bus.inByteMask);
    push       = vin & ((count_q != CW'(DEPTH)) | pop);
    drop       = vin & (count_q == CW'(DEPTH)) & ~pop;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push & ~pop) count_d = count_q + 1'b1;
    if (pop & ~push) count_d = count_q - 1'b1;
  end

  // Control state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage; contents are don't-care until count covers them
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= '{data: bus.inData,
                           mask: bus.inByteMask,
                           len:  popcnt(bus.inByteMask)};
  end

  // Registered-only outputs, zeroed while empty
  always_comb begin
    head            = mem_q[rd_ptr_q];
    bus.outValid    = valid;
    bus.outData     = valid ? head.data : '0;
    bus.outByteMask = valid ? head.mask : '0;
    bus.outLength   = valid ? head.len  : '0;
    bus.almostFull  = (count_q >= CW'(AFULL_THRESH));
    bus.overflow    = overflow_q;
  end

`ifdef MSG_OUT_BUF_STATS_EN
  logic [31:0] msg_cnt_q, msg_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Saturating statistics next-state
  always_comb begin
    msg_cnt_d  = msg_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (push & ~(&msg_cnt_q))  msg_cnt_d  = msg_cnt_q + 1'b1;
    if (drop & ~(&drop_cnt_q)) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  // Statistics registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      msg_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      msg_cnt_q  <= msg_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign msgCount  = msg_cnt_q;
  assign dropCount = drop_cnt_q;
`endif
endmodule

// File: doc/msg_out_buffer.md
# msg_out_buffer

Elastic output buffer placed directly downstream of the message decoder. It captures each decoded message word (up to 256-bit payload plus byte mask) in the cycle the decoder presents it, then replays it on a valid/ready interface so downstream logic can apply backpressure the decoder itself cannot. It also tags every stored message with its byte length and raises an early-warning flag, so upstream control can throttle the decoder's `inReady`.

## Interface
- `DATA_WIDTH`, 256, message payload width in bits.
- `BYTE_MASK_WIDTH`, 32, byte mask width; must equal `DATA_WIDTH/8`.
- `DEPTH`, 8, number of message entries; power of two, at least 2.
- `AFULL_THRESH`, 6, occupancy at which `almostFull` asserts; range 1..`DEPTH`.
- `clk`  in  1  single clock, rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `inValid`  in  1  decoder output word valid; no backpressure on this side.
- `inData`  in  `DATA_WIDTH`  decoded message payload, stored unmodified.
- `inByteMask`  in  `BYTE_MASK_WIDTH`  one bit per valid payload byte.
- `outValid`  out  1  head entry available.
- `outReady`  in  1  downstream accepts the head entry.
- `outData`  out  `DATA_WIDTH`  head payload.
- `outByteMask`  out  `BYTE_MASK_WIDTH`  head mask.
- `outLength`  out  6  popcount of the head mask, 0..32.
- `almostFull`  out  1  occupancy >= `AFULL_THRESH`.
- `overflow`  out  1  sticky; a valid input word was lost.

## Operation
- Storage is a circular buffer of `DEPTH` entries. Each entry holds {data, mask, length}. Write and read pointers are log2(`DEPTH`) bits and wrap naturally. The occupancy counter is log2(`DEPTH`)+1 bits.
- Length is computed at write time as the popcount of `inByteMask` and stored with the entry. The mask is not checked for contiguity.
- Write: `inValid`=1 and `inByteMask`!=0 and (count<`DEPTH` or pop in the same cycle).
- Zero-mask words with `inValid`=1 are discarded silently. They are not stored and do not set `overflow`.
- Pop: `outValid`=1 and `outReady`=1 at the clock edge.
- Push and pop in the same cycle leave the count unchanged. This holds when count=`DEPTH` (the write is accepted into the freed slot) and when count=1.
- When count=0, a pop cannot occur; a same-cycle push simply raises the count to 1.
- Drop: `inValid`=1, mask!=0, count=`DEPTH`, no pop. The word is lost, pointers and count are unchanged, and `overflow` is set. `overflow` clears only on `reset`.
- `outValid` = (count!=0).
- `outData`, `outByteMask` and `outLength` are driven from the head entry while `outValid`=1 and are forced to 0 while `outValid`=0.
- Downstream must hold `outReady` independently of `outValid`. The block never deasserts `outValid` without a pop.

## Timing
- Reset (asynchronous assert; deassert synchronised externally):
  - pointers and count go to 0;
  - `outValid`, `almostFull`, `overflow` go to 0;
  - `outData`, `outByteMask`, `outLength` go to 0.
- Contents in flight are discarded on reset; mid-stream reset is legal at any cycle.
- Latency: a word written at edge N appears on the outputs with `outValid`=1 after edge N, i.e. it is sampleable at edge N+1.
- Throughput: one write and one read per cycle sustained.
- `almostFull` and `outValid` are decoded from the registered count. Both update on the edge that changes the count, with no further delay.
- Outputs depend only on registers; there is no combinational path from `inValid` or `outReady` to any output.

## Configuration
- `MSG_OUT_BUF_STATS_EN` defined:
  - adds output `msgCount` [31:0], incremented on each accepted write;
  - adds output `dropCount` [15:0], incremented on each overflow drop;
  - both counters saturate at all-ones and reset to 0.
  - Zero-mask discards are counted in neither.
- Undefined: both ports and both counters are absent. All other behaviour is identical.

## Test plan
- Single message, reset released, `outReady`=1:
  - stimulus: one word with 9 bytes of 0x62, mask 0x000001FF;
  - response: `outValid` high for exactly 1 cycle, with `outLength`=9 and data/mask unchanged.
- Three back-to-back words, `outReady`=0:
  - stimulus: masks 0x1FF, 0x7FF, 0x3FFF (lengths 9, 11, 14); then raise `outReady`;
  - response: outputs in order with lengths 9, 11, 14; `outValid` drops after the third pop.
- Fill with `outReady`=0, `DEPTH`=8, `AFULL_THRESH`=6:
  - `almostFull` rises after the 6th write;
  - a 9th write sets `overflow` and the entry is lost;
  - draining yields exactly 8 entries; `dropCount`=1 when stats are enabled.
- Full buffer, push and pop in the same cycle:
  - the new word is accepted, count stays 8 and `overflow` stays 0;
  - the pushed word emerges 8th on drain.
- Zero-mask word mixed between two valid words:
  - only 2 entries are stored, `overflow`=0, and `msgCount`=2 when stats are enabled.
- `reset` pulsed with 5 entries held:
  - all outputs go to 0 immediately, with no wait for a clock edge;
  - after release, new writes are served starting from an empty buffer.
